// File: rtl/phys_reg_release.sv
// phys_reg_release: fills the free list with IDs ARCH_REGS..PHYS_REGS-1, then queues retired IDs back into it.
// Define PHYS_REG_RELEASE_DUAL_PORT_EN to accept both retire ports per cycle.
module phys_reg_release #(
    parameter int PHYS_REGS   = 64,
    parameter int ARCH_REGS   = 32,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   retire_valid,
    input  logic [$clog2(PHYS_REGS)-1:0] retire_phys_addr0,
    input  logic [$clog2(PHYS_REGS)-1:0] retire_phys_addr1,
    output logic                         retire_ready,
    input  logic                         fl_full,
    output logic                         fl_push,
    output logic                         fl_potential_push,
    output logic [$clog2(PHYS_REGS)-1:0] fl_data_in,
    output logic                         init_done
);
    localparam int AW = $clog2(PHYS_REGS);
    localparam int QW = $clog2(QUEUE_DEPTH);
`ifdef PHYS_REG_RELEASE_DUAL_PORT_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif
    typedef enum logic {INIT, RUN} state_t;
    state_t r_state, w_next;
    logic [AW-1:0] r_init_count;
    logic [AW-1:0] r_queue [QUEUE_DEPTH];
    logic [QW-1:0] r_rd, r_wr, w_wr1;
    logic [QW:0]   r_count, w_free;
    logic          w_run, w_enq0, w_enq1, w_deq;
    assign w_run = r_state == RUN;
    // Outputs are gated by rst so the reset cycle is quiet regardless of prior state.
    always_comb begin
        w_free            = (QW+1)'(QUEUE_DEPTH) - r_count;
        retire_ready      = ~rst & w_run & (w_free >= (QW+1)'(NEED));
        fl_potential_push = ~rst & (w_run ? r_count != '0 : 1'b1);
        fl_push           = fl_potential_push & ~fl_full;
        fl_data_in        = w_run ? r_queue[r_rd] : r_init_count;
        init_done         = ~rst & w_run;
        w_deq             = fl_push & w_run;
        w_enq0            = retire_ready & retire_valid[0] & (retire_phys_addr0 != '0);
`ifdef PHYS_REG_RELEASE_DUAL_PORT_EN
        w_enq1            = retire_ready & retire_valid[1] & (retire_phys_addr1 != '0);
`else
        w_enq1            = 1'b0;
`endif
        w_wr1             = r_wr + QW'(w_enq0);
        w_next            = (!w_run && fl_push && r_init_count == AW'(PHYS_REGS - 1)) ? RUN : r_state;
    end
`ifndef PHYS_REG_RELEASE_DUAL_PORT_EN
    logic w_unused;
    assign w_unused = retire_valid[1];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_init_count <= AW'(ARCH_REGS);
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_next;
            if (!w_run && fl_push) r_init_count <= r_init_count + 1'b1;
            if (w_deq) r_rd <= r_rd + 1'b1;
            r_wr    <= r_wr + QW'(w_enq0) + QW'(w_enq1);
            r_count <= r_count + (QW+1)'(w_enq0) + (QW+1)'(w_enq1) - (QW+1)'(w_deq);
        end
    end
    // Port 1 lands one slot after port 0 when both enqueue together.
    always_ff @(posedge clk) begin
        if (w_enq0) r_queue[r_wr] <= retire_phys_addr0;
        if (w_enq1) r_queue[w_wr1] <= retire_phys_addr1;
    end
endmodule

// File: doc/phys_reg_release.md
PHYS_REG_RELEASE -- requirements
Module: phys_reg_release

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 64, total physical registers; power of 2.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural registers; less than PHYS_REGS.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8, release-queue entries; power of 2, at least 4.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port retire_valid  input  2  per-port retire request: bit0 port 0, bit1 port 1.
REQ-007 SHALL have port retire_phys_addr0  input  $clog2(PHYS_REGS)  freed physical register, port 0.
REQ-008 SHALL have port retire_phys_addr1  input  $clog2(PHYS_REGS)  freed physical register, port 1.
REQ-009 SHALL have port retire_ready  output  1  retire requests accepted this cycle.
REQ-010 SHALL have port fl_full  input  1  free list cannot take a push this cycle.
REQ-011 SHALL have port fl_push  output  1  push fl_data_in into free list.
REQ-012 SHALL have port fl_potential_push  output  1  data valid for free-list RAM write; may assert without fl_push.
REQ-013 SHALL have port fl_data_in  output  $clog2(PHYS_REGS)  physical register ID being pushed.
REQ-014 SHALL have port init_done  output  1  initial fill complete; block in RUN.

Function
REQ-015 SHALL implement a two-state FSM: INIT, RUN.
REQ-016 In INIT, SHALL present init_count on fl_data_in with fl_potential_push=1, fl_push=~fl_full; init_count starts at ARCH_REGS.
REQ-017 In INIT, SHALL increment init_count only on cycles with fl_push=1.
REQ-018 SHALL move INIT->RUN on the cycle the push of PHYS_REGS-1 completes; RUN is held until rst.
REQ-019 In INIT, SHALL drive retire_ready=0 and ignore retire_valid.
REQ-020 In RUN, SHALL set retire_ready=1 when queue free slots >= 2 (dual port) or >= 1 (single port), else 0.
REQ-021 SHALL enqueue an accepted retire port only when its valid bit=1, retire_ready=1, and address != 0; address 0 is silently dropped.
REQ-022 With both ports enqueued in one cycle, SHALL place port 0 before port 1 in queue order.
REQ-023 In RUN, SHALL drive fl_potential_push=queue non-empty, fl_data_in=queue head, fl_push=non-empty & ~fl_full.
REQ-024 SHALL dequeue the head on every cycle fl_push=1; at most one push per cycle.
REQ-025 Latency: an entry accepted in cycle N SHALL reach fl_data_in no earlier than cycle N+1; there is no same-cycle bypass.
REQ-026 SHALL update occupancy as count + enqueued - dequeued, all in one cycle; simultaneous enqueue and dequeue at full or empty SHALL be exact.
REQ-027 Queue read/write indices SHALL wrap modulo QUEUE_DEPTH; occupancy SHALL use $clog2(QUEUE_DEPTH)+1 bits.
REQ-028 SHALL never overflow; occupancy SHALL never exceed QUEUE_DEPTH, guaranteed by REQ-020.
REQ-029 init_done SHALL be 1 exactly when state=RUN.

Reset
REQ-030 On rst, SHALL set state=INIT, init_count=ARCH_REGS, occupancy=0, and both indices=0.
REQ-031 During rst cycle outputs SHALL be fl_push=0, fl_potential_push=0, retire_ready=0, init_done=0; queue RAM contents are not reset.
REQ-032 rst asserted mid-INIT or mid-RUN SHALL discard all pending entries and restart the fill from ARCH_REGS on the next cycle.

Configuration
REQ-033 Macro PHYS_REG_RELEASE_DUAL_PORT_EN defined: SHALL accept both retire ports per cycle, with the 2-slot threshold on retire_ready.
REQ-034 Macro PHYS_REG_RELEASE_DUAL_PORT_EN undefined: SHALL ignore retire_valid[1] and retire_phys_addr1, with the 1-slot threshold on retire_ready.

Verification
REQ-035 Reset, fl_full=0, defaults -> pushes 32,33,...,63 on 32 consecutive cycles, then init_done=1 on the cycle after the push of 63.
REQ-036 Fill with fl_full toggling 1,0 every cycle -> each ID pushed exactly once in order; INIT lasts 64 cycles.
REQ-037 RUN, dual port, retire_valid=2'b11, addr0=40, addr1=7 -> fl_data_in 40 then 7 on the next two cycles, each with fl_push=1.
REQ-038 RUN, retire_valid=2'b01, addr0=0 -> no enqueue; fl_push stays 0.
REQ-039 RUN, fl_full=1 held, dual pushes each cycle -> retire_ready drops once occupancy reaches 7; count saturates at 8 with no lost or duplicated IDs after fl_full releases.
REQ-040 rst pulsed with 5 entries queued -> queue empties; next pushes restart at ID 32.
